dual_port_ram: RTL
==================

# dual_port_ram

Parametrised dual-port synchronous RAM between the CPU and the video fetch path: port A is the CPU read/write port, port B is a read-only port for the tile/sprite fetch logic. Both ports have registered one-cycle reads. A built-in fill engine clears the whole array to a constant after reset or on request, so no contents are preloaded. A busy/ready handshake blocks the CPU while a fill runs.

## Interface
- AddrBits, default 16: address width; Depth = 1 << AddrBits words.
- DataBits, default 8: word width.
- FillOnReset, default 1: 1 = start a fill when reset deasserts; 0 = go straight to normal operation.
- FillValue, default 0: DataBits-wide constant written by the fill engine.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fill  in  1  one-cycle pulse that starts a full-array fill; ignored while busy.
- busy  out  1  high while a fill is in progress.
- aWriteEnabled  in  1  port A write strobe.
- aAddress  in  AddrBits  port A address.
- aDataIn  in  DataBits  port A write data.
- aDataOut  out  DataBits  port A registered read data.
- aReady  out  1  equals !busy; port A accesses count only when high.
- bReadEnabled  in  1  port B read strobe.
- bAddress  in  AddrBits  port B address.
- bDataOut  out  DataBits  port B registered read data.
- bValid  out  1  one-cycle pulse marking bDataOut as new.

## Operation
- States: FILL and RUN.
- Reset asserted: go to FILL if FillOnReset=1, else RUN. Clear the fill counter. Set aDataOut=0, bDataOut=0, bValid=0. busy and aReady follow the state. Array contents are not reset.
- FILL:
  - Each edge writes FillValue to memory[counter], then counter increments.
  - The edge that writes Depth-1 moves to RUN and clears the counter.
  - Port A writes are ignored; aDataOut and bDataOut hold their values; bValid=0.
  - bReadEnabled is dropped, not queued.
- RUN, port A:
  - On each edge, aDataOut <= memory[aAddress].
  - If aWriteEnabled, memory[aAddress] <= aDataIn, and aDataOut takes aDataIn on that same edge (write-first).
- RUN, port B:
  - If bReadEnabled, bDataOut <= memory[bAddress] and bValid=1 for the next cycle.
  - Otherwise bDataOut holds and bValid=0.
- Collision, A write and B read to the same address in the same cycle: bDataOut returns aDataIn (write-first forward).
- fill asserted in RUN: move to FILL on that edge with counter=0. Any port A write in that same cycle is still performed, and is then overwritten by the fill.
- Counter is AddrBits+1 wide, or compares against Depth-1, so it does not wrap early when AddrBits is large.

## Timing
- Read latency is 1 cycle on both ports; writes take effect at the sampling edge.
- A fill lasts exactly Depth edges.
  - With FillOnReset=1, the first edge after reset deasserts writes address 0.
  - busy falls after the edge that writes Depth-1; the first accepted CPU access is on the following edge.
- Reset asserted during a fill: outputs clear immediately (asynchronous). The fill restarts from address 0 after release, or is abandoned if FillOnReset=0, leaving a partially filled array.
- fill pulse during FILL: no effect; the running fill is not restarted.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use AddrBits=4, DataBits=8, FillValue=8'hA5, FillOnReset=1 unless stated.
- Release reset, wait: busy stays high exactly 16 edges then falls. Port A reads of addresses 0..15 each return 8'hA5 one cycle after the address is presented.
- RUN: write 8'h3C to address 5. The same edge shows aDataOut=8'h3C. Reading address 5 on the next cycle gives 8'h3C; address 6 gives 8'hA5.
- RUN: in the same cycle, write 8'h77 to address 9 on A and read address 9 on B. The next cycle shows bDataOut=8'h77 and bValid=1; bValid is 0 one cycle later.
- During FILL: write 8'h11 to address 15 and pulse bReadEnabled. After the fill, address 15 reads 8'hA5, and bValid was never high during the fill.
- After writing addresses 0..15 with their own index, pulse fill, then assert reset at fill edge 7 and release. A fresh 16-edge fill runs and every address reads 8'hA5. A second build with FillOnReset=0 shows busy=0 right after reset, and addresses 7..15 still hold their index values.

Source files
------------

// File: rtl/dual_port_ram.sv
// Dual-port synchronous RAM shared by the CPU (port A, read/write) and the
// video fetch path (port B, read-only). A fill engine writes FillValue to
// every word after reset (optional) or on a fill request; the CPU is held
// off through busy/aReady while that runs.
//
// state  | meaning
// S_FILL | fill engine owns the array, one word per edge, ports A/B idle
// S_RUN  | normal operation, port A read/write, port B read
module dual_port_ram #(
  parameter int                  AddrBits    = 16,
  parameter int                  DataBits    = 8,
  parameter bit                  FillOnReset = 1'b1,
  parameter logic [DataBits-1:0] FillValue   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fill,
  output logic                busy,
  input  logic                aWriteEnabled,
  input  logic [AddrBits-1:0] aAddress,
  input  logic [DataBits-1:0] aDataIn,
  output logic [DataBits-1:0] aDataOut,
  output logic                aReady,
  input  logic                bReadEnabled,
  input  logic [AddrBits-1:0] bAddress,
  output logic [DataBits-1:0] bDataOut,
  output logic                bValid
);

  localparam int Depth = 1 << AddrBits;
  // Terminal count held at address width so large AddrBits cannot wrap early.
  localparam logic [AddrBits-1:0] LastAddr = AddrBits'(Depth - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam state_t ResetState = FillOnReset ? S_FILL : S_RUN;

  state_t              state;
  state_t              state_next;
  logic [AddrBits-1:0] fill_cnt;
  logic [AddrBits-1:0] fill_cnt_next;

  logic [DataBits-1:0] mem [Depth];
  logic                mem_we;
  logic [AddrBits-1:0] mem_waddr;
  logic [DataBits-1:0] mem_wdata;
  logic                b_fwd;

  assign busy   = (state == S_FILL);
  assign aReady = (state == S_RUN);
  // A write and B read to the same word in one cycle: B sees the new data.
  assign b_fwd  = aWriteEnabled && (aAddress == bAddress);

  // State register and fill counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ResetState;
      fill_cnt <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_cnt_next;
    end
  end

  // Next-state logic: fill walks the whole array, a fill request in RUN restarts it.
  always_comb begin
    state_next    = state;
    fill_cnt_next = fill_cnt;
    case (state)
      S_FILL: begin
        if (fill_cnt == LastAddr) begin
          state_next    = S_RUN;
          fill_cnt_next = '0;
        end else begin
          fill_cnt_next = fill_cnt + 1'b1;
        end
      end
      S_RUN: begin
        fill_cnt_next = '0;
        if (fill) begin
          state_next = S_FILL;
        end
      end
      default: begin
        state_next    = S_RUN;
        fill_cnt_next = '0;
      end
    endcase
  end

  // Single write port: the fill engine owns it during FILL, port A otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = aAddress;
    mem_wdata = aDataIn;
    if (state == S_FILL) begin
      mem_we    = 1'b1;
      mem_waddr = fill_cnt;
      mem_wdata = FillValue;
    end else if (aWriteEnabled) begin
      mem_we = 1'b1;
    end
  end

  // Array storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read ports; both hold their data while a fill runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aDataOut <= '0;
      bDataOut <= '0;
      bValid   <= 1'b0;
    end else if (state == S_RUN) begin
      aDataOut <= aWriteEnabled ? aDataIn : mem[aAddress];
      bValid   <= bReadEnabled;
      if (bReadEnabled) begin
        bDataOut <= b_fwd ? aDataIn : mem[bAddress];
      end
    end else begin
      bValid <= 1'b0;
    end
  end

endmodule
